// File: rtl/irq_fifo_pkg.sv
// Shared NoC constants for the interrupt FIFO block: the SPM address width
// and the encoding of the processor's queue-select bit.
package irq_fifo_pkg;

    localparam int ADDR_W = 14;

    localparam logic SEL_DATA = 1'b0;
    localparam logic SEL_IRQ  = 1'b1;

endpackage

// File: rtl/irq_fifo_queue.sv
// One circular-buffer queue: write/read pointers that wrap naturally and an
// occupancy count one bit wider than the pointers so full and empty differ.
module irq_fifo_queue
    import irq_fifo_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int W     = ADDR_W
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [W-1:0]           push_data,
    input  logic                   pop,
    output logic [W-1:0]           head,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow
);

    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          full;
    logic          do_push;
    logic          do_pop;

    assign full  = (count == (PW+1)'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

    // A pop on a full queue frees the slot the simultaneous push lands in.
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign overflow = push && full && !do_pop;

    always_ff @(posedge clk) begin
        if (do_push && !reset) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/irq_fifo.sv
// Data-arrival and remote-IRQ queues behind one processor read port, with
// level interrupts per queue and sticky overflow flags cleared by a read.
module irq_fifo
    import irq_fifo_pkg::*;
#(
    parameter int DATA_DEPTH = 16,
    parameter int IRQ_DEPTH  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] irq_fifo_data,
    input  logic              irq_fifo_data_valid,
    input  logic              irq_fifo_irq_valid,
    input  logic              rd_en,
    input  logic              rd_sel,
    output logic [ADDR_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              rd_hit,
    output logic              irq_data,
    output logic              irq_irq,
    output logic [1:0]        ovf
);

    logic [ADDR_W-1:0]           data_head;
    logic [ADDR_W-1:0]           irq_head;
    logic                        data_empty;
    logic                        irq_empty;
    logic [$clog2(DATA_DEPTH):0] data_count;
    logic [$clog2(IRQ_DEPTH):0]  irq_count;
    logic                        data_ovf;
    logic                        irq_ovf;
    logic                        data_rd;
    logic                        irq_rd;
    logic                        sel_empty;
    logic [ADDR_W-1:0]           sel_head;

    assign data_rd = rd_en && (rd_sel == SEL_DATA);
    assign irq_rd  = rd_en && (rd_sel == SEL_IRQ);

    irq_fifo_queue #(.DEPTH(DATA_DEPTH), .W(ADDR_W)) u_data_q (
        .clk       (clk),
        .reset     (reset),
        .push      (irq_fifo_data_valid),
        .push_data (irq_fifo_data),
        .pop       (data_rd),
        .head      (data_head),
        .empty     (data_empty),
        .count     (data_count),
        .overflow  (data_ovf)
    );

    irq_fifo_queue #(.DEPTH(IRQ_DEPTH), .W(ADDR_W)) u_irq_q (
        .clk       (clk),
        .reset     (reset),
        .push      (irq_fifo_irq_valid),
        .push_data (irq_fifo_data),
        .pop       (irq_rd),
        .head      (irq_head),
        .empty     (irq_empty),
        .count     (irq_count),
        .overflow  (irq_ovf)
    );

    assign sel_empty = (rd_sel == SEL_IRQ) ? irq_empty : data_empty;
    assign sel_head  = (rd_sel == SEL_IRQ) ? irq_head  : data_head;

    // Read handshake: no ready; every rd_en cycle yields exactly one rd_valid
    // pulse on the next cycle, with rd_hit=0 and rd_data=0 for an empty queue.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
            rd_hit   <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            rd_hit   <= rd_en && !sel_empty;
            if (rd_en) begin
                rd_data <= sel_empty ? '0 : sel_head;
            end
        end
    end

    // A fresh overflow wins over a clearing read in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            ovf      <= 2'b00;
            irq_data <= 1'b0;
            irq_irq  <= 1'b0;
        end else begin
            ovf[0]   <= data_ovf || (ovf[0] && !data_rd);
            ovf[1]   <= irq_ovf  || (ovf[1] && !irq_rd);
            irq_data <= (data_count != '0);
            irq_irq  <= (irq_count != '0);
        end
    end

endmodule

// File: tb/tb_irq_fifo.sv
// Self-checking bench for irq_fifo: a reference model of both queues feeds an
// expected-response queue that is drained as read responses appear.
module tb_irq_fifo;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic [13:0] irq_fifo_data;
    logic        irq_fifo_data_valid;
    logic        irq_fifo_irq_valid;
    logic        rd_en;
    logic        rd_sel;
    logic [13:0] rd_data;
    logic        rd_valid;
    logic        rd_hit;
    logic        irq_data;
    logic        irq_irq;
    logic [1:0]  ovf;

    int checks   = 0;
    int failures = 0;

    logic [14:0] exp_q[$];
    logic [13:0] data_m[$];
    logic [13:0] irq_m[$];
    logic [1:0]  ovf_m;

    irq_fifo #(.DATA_DEPTH(DEPTH), .IRQ_DEPTH(DEPTH)) dut (
        .clk                 (clk),
        .reset               (reset),
        .irq_fifo_data       (irq_fifo_data),
        .irq_fifo_data_valid (irq_fifo_data_valid),
        .irq_fifo_irq_valid  (irq_fifo_irq_valid),
        .rd_en               (rd_en),
        .rd_sel              (rd_sel),
        .rd_data             (rd_data),
        .rd_valid            (rd_valid),
        .rd_hit              (rd_hit),
        .irq_data            (irq_data),
        .irq_irq             (irq_irq),
        .ovf                 (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        irq_fifo_data       = '0;
        irq_fifo_data_valid = 1'b0;
        irq_fifo_irq_valid  = 1'b0;
        rd_en               = 1'b0;
        rd_sel              = 1'b0;
    endtask

    // One clock of stimulus; the model pops before it pushes, so an empty
    // read never sees an entry pushed in the same cycle.
    task automatic cycle(input logic dv, input logic iv, input logic [13:0] d,
                         input logic ren, input logic rsel);
        logic        pre_d;
        logic        pre_i;
        logic [1:0]  ov_now;
        logic [14:0] e;
        pre_d  = (data_m.size() != 0);
        pre_i  = (irq_m.size() != 0);
        ov_now = 2'b00;
        irq_fifo_data       = d;
        irq_fifo_data_valid = dv;
        irq_fifo_irq_valid  = iv;
        rd_en               = ren;
        rd_sel              = rsel;
        if (ren) begin
            if (!rsel) begin
                if (data_m.size() > 0) exp_q.push_back({1'b1, data_m.pop_front()});
                else                   exp_q.push_back(15'd0);
            end else begin
                if (irq_m.size() > 0) exp_q.push_back({1'b1, irq_m.pop_front()});
                else                  exp_q.push_back(15'd0);
            end
        end
        if (dv) begin
            if (data_m.size() < DEPTH) data_m.push_back(d);
            else                       ov_now[0] = 1'b1;
        end
        if (iv) begin
            if (irq_m.size() < DEPTH) irq_m.push_back(d);
            else                      ov_now[1] = 1'b1;
        end
        ovf_m[0] = ov_now[0] | (ovf_m[0] & ~(ren & ~rsel));
        ovf_m[1] = ov_now[1] | (ovf_m[1] & ~(ren & rsel));
        @(posedge clk);
        #1;
        idle_inputs();
        check("rd_valid", 32'(rd_valid), 32'(ren));
        if (rd_valid && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("rd_hit", 32'(rd_hit), 32'(e[14]));
            check("rd_data", 32'(rd_data), 32'(e[13:0]));
        end
        check("irq_data", 32'(irq_data), 32'(pre_d));
        check("irq_irq", 32'(irq_irq), 32'(pre_i));
        check("ovf", 32'(ovf), 32'(ovf_m));
    endtask

    // Reset cycle, optionally with a push and a read that must both be lost.
    task automatic do_reset(input logic dv, input logic ren);
        reset               = 1'b1;
        irq_fifo_data       = 14'h0AAA;
        irq_fifo_data_valid = dv;
        rd_en               = ren;
        rd_sel              = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle_inputs();
        data_m.delete();
        irq_m.delete();
        exp_q.delete();
        ovf_m = 2'b00;
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_rd_hit", 32'(rd_hit), 32'd0);
        check("rst_rd_data", 32'(rd_data), 32'd0);
        check("rst_irq_data", 32'(irq_data), 32'd0);
        check("rst_irq_irq", 32'(irq_irq), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        ovf_m = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        do_reset(1'b0, 1'b0);

        // Single data push and read; irq_data follows one cycle behind.
        cycle(1'b1, 1'b0, 14'h0010, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 14'h0000, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 14'h0000, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 14'h0000, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 14'h0000, 1'b0, 1'b0);

        // Overflow the data queue, drain it, then one empty read.
        for (int i = 0; i <= DEPTH; i++) cycle(1'b1, 1'b0, 14'(i), 1'b0, 1'b0);
        check("ovf_after_fill", 32'(ovf), 32'd1);
        for (int i = 0; i <= DEPTH; i++) cycle(1'b0, 1'b0, 14'h0, 1'b1, 1'b0);
        check("data_empty_hit", 32'(rd_hit), 32'd0);

        // Full IRQ queue: simultaneous push and pop must not overflow.
        for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b1, 14'($urandom_range(0, 16383)), 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 14'h3FFF, 1'b1, 1'b1);
        for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b0, 14'h0, 1'b1, 1'b1);
        check("irq_last_entry", 32'(rd_data), 32'h3FFF);
        cycle(1'b0, 1'b0, 14'h0, 1'b1, 1'b1);

        // Dual push lands in both queues.
        cycle(1'b1, 1'b1, 14'h0123, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 14'h0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 14'h0, 1'b1, 1'b1);
        cycle(1'b0, 1'b0, 14'h0, 1'b0, 1'b0);

        // Reset during a read with pending entries.
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 14'(100 + i), 1'b0, 1'b0);
        do_reset(1'b1, 1'b1);
        cycle(1'b0, 1'b0, 14'h0, 1'b1, 1'b0);

        // Empty read with a same-cycle push: no fall-through.
        cycle(1'b1, 1'b0, 14'h0555, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 14'h0, 1'b1, 1'b0);

        // Interleaved push/pop on the data queue to exercise pointer wrap.
        for (int i = 0; i < 40; i++)
            cycle(1'($urandom_range(0, 3) != 0), 1'b0, 14'($urandom_range(0, 16383)),
                  1'($urandom_range(0, 1)), 1'b0);

        // Random traffic on both queues, biased to reach full and empty.
        for (int i = 0; i < 300; i++)
            cycle(1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 2) == 0),
                  14'($urandom_range(0, 16383)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)));

        for (int i = 0; i < 2 * DEPTH; i++) cycle(1'b0, 1'b0, 14'h0, 1'b1, 1'(i % 2));
        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
